mic1_regfile: RTL
=================

# mic1_regfile

MIC-1 datapath register file and C-bus write-back stage, wrapped around the ALU. It drives the B bus and the H operand into the ALU, takes the ALU result through the shifter, and writes it to the selected registers. It latches the N/Z flags for the microsequencer and runs the data-memory port (MAR/MDR) and the instruction-fetch port (PC/MBR) handshakes.

## Interface
- `DATA_W`, 32: width of registers and buses.
- `SP_INIT`, 32'h0000_8000: SP reset value.
- `LV_INIT`, 32'h0000_8000: LV reset value.
- `CPP_INIT`, 32'h0000_4000: CPP reset value.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_out` in DATA_W: ALU result, pre-shift.
- `alu_n`, `alu_z` in 1: ALU N and Z outputs.
- `sll8`, `sra1` in 1: shifter controls.
- `c_en` in 9: C-bus write enables. Bit order, bit 0 first: H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR.
- `b_sel` in 4: B-bus source code.
- `rd`, `wr`, `fetch` in 1: memory microinstruction bits.
- `b_bus` out DATA_W: B operand to the ALU.
- `h_out` out DATA_W: H register, the A operand to the ALU.
- `n_flag`, `z_flag` out 1: latched flags.
- `mem_addr` out DATA_W: word address, equal to MAR.
- `mem_wdata` out DATA_W: equal to MDR.
- `mem_rd_req`, `mem_wr_req` out 1: one-cycle request pulses.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in DATA_W: read data.
- `if_addr` out DATA_W: byte address, equal to PC.
- `if_req` out 1: one-cycle fetch request pulse.
- `if_valid` in 1: fetched byte valid.
- `if_data` in 8: fetched byte.
- `mem_err` out 1: sticky protocol-error flag.

## Operation
- B-bus decode (combinational from `b_sel`):
  - 0 MDR, 1 PC, 2 MBR sign-extended, 3 MBR zero-extended, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC.
  - Codes 9–15 drive all zeros.
- Shifter output S:
  - `sll8` set: alu_out<<8, zero-filled.
  - `sra1` set (and `sll8` clear): arithmetic right shift by 1, bit 31 replicated.
  - Neither set: alu_out unchanged.
  - Both set: `sll8` takes priority.
- Write-back: each register whose `c_en` bit is set loads S. Any combination of bits is legal in one cycle.
- Flags: `n_flag`/`z_flag` register `alu_n`/`alu_z` every cycle, unconditionally.
- Data port is single-outstanding, with states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE:
  - IDLE + `rd` -> RD_ISSUE. IDLE + `wr` -> WR_ISSUE.
  - RD_ISSUE pulses `mem_rd_req` with the current MAR, then -> RD_WAIT.
  - RD_WAIT + `mem_rvalid` loads MDR from `mem_rdata` -> IDLE.
  - WR_ISSUE pulses `mem_wr_req` with the current MAR/MDR -> IDLE.
  - `rd` and `wr` in the same cycle: set `mem_err`, ignore both.
  - `rd` or `wr` while not IDLE: set `mem_err`, drop the request.
- Fetch port is single-outstanding, with states F_IDLE, F_ISSUE, F_WAIT:
  - F_IDLE + `fetch` -> F_ISSUE.
  - F_ISSUE pulses `if_req` with the current PC -> F_WAIT.
  - F_WAIT + `if_valid` loads MBR -> F_IDLE.
  - `fetch` while busy sets `mem_err`.
  - The fetch and data ports run independently and concurrently.
- Conflicts:
  - `mem_rvalid` in the same cycle as `c_en[MDR]`: the memory data wins.
  - `mem_rvalid` or `if_valid` outside RD_WAIT / F_WAIT: ignored, and sets `mem_err`.
- Reset:
  - SP, LV, CPP load their `*_INIT` values. All other registers, MBR and flags clear to 0.
  - Both FSMs return to idle; request outputs go low; `mem_err` clears.
  - An in-flight access is abandoned; a late `mem_rvalid` after reset sets `mem_err`.

## Timing
- `b_bus`, `h_out`, `mem_addr`, `mem_wdata`, `if_addr` are combinational from register state; no added latency.
- Write-back and flags become visible the cycle after the microinstruction that produces them.
- `rd` in cycle k: the request goes out in k+1 using MAR as written in k, so MAR:=x; rd in one microinstruction reads address x. MDR is earliest usable in the cycle after `mem_rvalid`.
- `fetch` in cycle k: `if_req` in k+1 using PC as written in k.
- Request pulses are registered, never combinational from inputs, and last exactly one cycle.

## Structure
- `mic1_pkg`:
  - B-select enum.
  - C-enable bit index constants.
  - Data-port and fetch-port state enums.
  - Default reset constants.
- One sub-module, `mic1_shifter`: a combinational SLL8/SRA1 unit. It is reused by a future stand-alone ALU+shifter bench.

## Test plan
- Shifter:
  - alu_out 32'h3AE9F840 with `sll8` -> H = 32'hE9F84000.
  - 32'h878AFE71 with `sra1` -> H = 32'hC3C57F38.
  - Both bits set -> SLL8 result.
- B-bus: after reset, `b_sel`=4 -> 32'h00008000. Load MBR 8'h9C via fetch, then `b_sel`=2 -> 32'hFFFFFF9C and `b_sel`=3 -> 32'h0000009C.
- Read: MAR:=32'h10 with `rd` -> `mem_rd_req` next cycle, addr 32'h10. `mem_rvalid` with 32'hDEADBEEF two cycles later -> MDR and `b_sel`=0 read DEADBEEF. Same-cycle `c_en[MDR]` still yields DEADBEEF.
- Error handling: second `rd` during RD_WAIT -> `mem_err` set, no second request. `rd`+`wr` together -> `mem_err`, no request.
- Concurrency: `fetch` and `wr` in the same cycle -> `if_req` and `mem_wr_req` both pulse next cycle.
- Reset mid-operation: `rst_n` low during RD_WAIT -> all outputs reset asynchronously. A subsequent `mem_rvalid` leaves MDR at 0 and sets `mem_err`.

Source files
------------

// File: rtl/mic1_pkg.sv
// Shared types and constants for the MIC-1 register file / write-back slice.
package mic1_pkg;

    typedef enum logic [3:0] {
        B_MDR  = 4'd0,
        B_PC   = 4'd1,
        B_MBR  = 4'd2,
        B_MBRU = 4'd3,
        B_SP   = 4'd4,
        B_LV   = 4'd5,
        B_CPP  = 4'd6,
        B_TOS  = 4'd7,
        B_OPC  = 4'd8
    } b_sel_e;

    localparam int unsigned C_H   = 0;
    localparam int unsigned C_OPC = 1;
    localparam int unsigned C_TOS = 2;
    localparam int unsigned C_CPP = 3;
    localparam int unsigned C_LV  = 4;
    localparam int unsigned C_SP  = 5;
    localparam int unsigned C_PC  = 6;
    localparam int unsigned C_MDR = 7;
    localparam int unsigned C_MAR = 8;
    localparam int unsigned C_W   = 9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } dport_state_e;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_ISSUE = 2'd1,
        F_WAIT  = 2'd2
    } fport_state_e;

    localparam logic [31:0] SP_INIT_DEF  = 32'h0000_8000;
    localparam logic [31:0] LV_INIT_DEF  = 32'h0000_8000;
    localparam logic [31:0] CPP_INIT_DEF = 32'h0000_4000;

endpackage

// File: rtl/mic1_regfile_if.sv
// Data-memory and instruction-fetch handshake bundle; master is the datapath side.
interface mic1_regfile_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] if_addr;
    logic              if_req;
    logic              if_valid;
    logic [7:0]        if_data;

    modport master (
        output mem_addr, mem_wdata, mem_rd_req, mem_wr_req, if_addr, if_req,
        input  mem_rvalid, mem_rdata, if_valid, if_data
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd_req, mem_wr_req, if_addr, if_req,
        output mem_rvalid, mem_rdata, if_valid, if_data
    );
endinterface

// File: rtl/mic1_shifter.sv
// Combinational MIC-1 shifter: SLL8 (priority) or arithmetic SRA1 of the ALU result.
module mic1_shifter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] alu_out,
    input  logic              sll8,
    input  logic              sra1,
    output logic [DATA_W-1:0] shift_out
);
    always_comb begin
        shift_out = alu_out;
        if (sll8)
            shift_out = {alu_out[DATA_W-9:0], 8'h00};
        else if (sra1)
            shift_out = {alu_out[DATA_W-1], alu_out[DATA_W-1:1]};
    end
endmodule

// File: rtl/mic1_regfile.sv
// MIC-1 register file, C-bus write-back, flag latch and the memory/fetch port FSMs.
module mic1_regfile
    import mic1_pkg::*;
#(
    parameter int unsigned      DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_INIT  = SP_INIT_DEF,
    parameter logic [DATA_W-1:0] LV_INIT  = LV_INIT_DEF,
    parameter logic [DATA_W-1:0] CPP_INIT = CPP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              sll8,
    input  logic              sra1,
    input  logic [C_W-1:0]    c_en,
    input  logic [3:0]        b_sel,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    output logic [DATA_W-1:0] b_bus,
    output logic [DATA_W-1:0] h_out,
    output logic              n_flag,
    output logic              z_flag,
    output logic              mem_err,
    mic1_regfile_if.master    bus
);
    logic [DATA_W-1:0] s_bus;
    logic [DATA_W-1:0] h, opc, tos, cpp, lv, sp, pc, mdr, mar;
    logic [7:0]        mbr;
    logic              rd_req, wr_req, f_req;
    logic              d_err, f_err;
    dport_state_e      dstate;
    fport_state_e      fstate;

    mic1_shifter #(.DATA_W(DATA_W)) u_shifter (
        .alu_out   (alu_out),
        .sll8      (sll8),
        .sra1      (sra1),
        .shift_out (s_bus)
    );

    always_comb begin
        b_bus = '0;
        case (b_sel_e'(b_sel))
            B_MDR:   b_bus = mdr;
            B_PC:    b_bus = pc;
            B_MBR:   b_bus = {{(DATA_W-8){mbr[7]}}, mbr};
            B_MBRU:  b_bus = {{(DATA_W-8){1'b0}}, mbr};
            B_SP:    b_bus = sp;
            B_LV:    b_bus = lv;
            B_CPP:   b_bus = cpp;
            B_TOS:   b_bus = tos;
            B_OPC:   b_bus = opc;
            default: b_bus = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h      <= '0;
            opc    <= '0;
            tos    <= '0;
            cpp    <= CPP_INIT;
            lv     <= LV_INIT;
            sp     <= SP_INIT;
            pc     <= '0;
            mar    <= '0;
            n_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            if (c_en[C_H])   h   <= s_bus;
            if (c_en[C_OPC]) opc <= s_bus;
            if (c_en[C_TOS]) tos <= s_bus;
            if (c_en[C_CPP]) cpp <= s_bus;
            if (c_en[C_LV])  lv  <= s_bus;
            if (c_en[C_SP])  sp  <= s_bus;
            if (c_en[C_PC])  pc  <= s_bus;
            if (c_en[C_MAR]) mar <= s_bus;
            n_flag <= alu_n;
            z_flag <= alu_z;
        end
    end

    always_comb begin
        d_err = (rd && wr) || ((rd || wr) && dstate != IDLE) ||
                (bus.mem_rvalid && dstate != RD_WAIT);
        f_err = (fetch && fstate != F_IDLE) || (bus.if_valid && fstate != F_WAIT);
    end

    // MDR lives here because a returning read overrides a C-bus write to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate <= IDLE;
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            mdr    <= '0;
        end else begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            if (dstate == RD_WAIT && bus.mem_rvalid)
                mdr <= bus.mem_rdata;
            else if (c_en[C_MDR])
                mdr <= s_bus;
            case (dstate)
                IDLE: begin
                    if (rd && !wr) begin
                        dstate <= RD_ISSUE;
                        rd_req <= 1'b1;
                    end else if (wr && !rd) begin
                        dstate <= WR_ISSUE;
                        wr_req <= 1'b1;
                    end
                end
                RD_ISSUE: dstate <= RD_WAIT;
                RD_WAIT:  if (bus.mem_rvalid) dstate <= IDLE;
                WR_ISSUE: dstate <= IDLE;
                default:  dstate <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate <= F_IDLE;
            f_req  <= 1'b0;
            mbr    <= '0;
        end else begin
            f_req <= 1'b0;
            case (fstate)
                F_IDLE: begin
                    if (fetch) begin
                        fstate <= F_ISSUE;
                        f_req  <= 1'b1;
                    end
                end
                F_ISSUE: fstate <= F_WAIT;
                F_WAIT: begin
                    if (bus.if_valid) begin
                        mbr    <= bus.if_data;
                        fstate <= F_IDLE;
                    end
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_err <= 1'b0;
        else if (d_err || f_err)
            mem_err <= 1'b1;
    end

    assign h_out          = h;
    assign bus.mem_addr   = mar;
    assign bus.mem_wdata  = mdr;
    assign bus.mem_rd_req = rd_req;
    assign bus.mem_wr_req = wr_req;
    assign bus.if_addr    = pc;
    assign bus.if_req     = f_req;
endmodule
